seven_seg_frame_reader: RTL and testbench

//  Reads back a multiplexed, active-low seven-segment display bus and recovers the BCD digits being shown.

---
 rtl/seven_seg_frame_reader.sv | 166 ++++++++++++++++
 tb/tb_seven_seg_frame_reader.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/seven_seg_frame_reader.sv
// Seven-segment read-back: syncs the multiplexed active-low display bus,
// debounces each digit, decodes segments back to BCD and assembles frames
// that are offered to a consumer over a valid/ready handshake.
module seven_seg_frame_reader #(
  parameter int unsigned DIGITS        = 4,
  parameter int unsigned STABLE_CYCLES = 3
) (
  input  logic                  Clock,
  input  logic                  Resetn,
  input  logic [6:0]            seg_n,
  input  logic [DIGITS-1:0]     dig_en,
  input  logic                  frame_ready,
  output logic                  frame_valid,
  output logic [4*DIGITS-1:0]   frame_bcd,
  output logic [DIGITS-1:0]     frame_err,
  output logic                  overrun
);

  localparam int unsigned CntW = (STABLE_CYCLES < 2) ? 1 : $clog2(STABLE_CYCLES + 1);
  localparam int unsigned SyncW = 7 + DIGITS;

  localparam logic [0:0] COLLECT = 1'b0;
  localparam logic [0:0] HOLD    = 1'b1;

  // Returns {err, value}; unknown patterns decode to 4'hF with err set.
  function automatic logic [4:0] decode_seg(input logic [6:0] s);
    logic [4:0] r;
    unique case (s)
      7'b0000001: r = 5'h00;
      7'b1001111: r = 5'h01;
      7'b0010010: r = 5'h02;
      7'b0000110: r = 5'h03;
      7'b1001100: r = 5'h04;
      7'b0100100: r = 5'h05;
      7'b0100000: r = 5'h06;
      7'b0001111: r = 5'h07;
      7'b0000000: r = 5'h08;
      7'b0000100: r = 5'h09;
      default:    r = 5'h1F;
    endcase
    return r;
  endfunction

  logic [SyncW-1:0]    sync_q;
  logic [CntW-1:0]     cnt_q;
  logic [4*DIGITS-1:0] bank_bcd_q, bank_bcd_d;
  logic [DIGITS-1:0]   bank_err_q, bank_err_d;
  logic [DIGITS-1:0]   seen_q, seen_d;
  logic [0:0]          state_q, state_d;
  logic                valid_q, valid_d;
  logic [4*DIGITS-1:0] bcd_q, bcd_d;
  logic [DIGITS-1:0]   err_q, err_d;
  logic                overrun_q, overrun_d;

  logic [SyncW-1:0]    raw;
  logic                same;
  logic [DIGITS-1:0]   dig;
  logic                onehot;
  logic                accept;
  logic [4:0]          dec;
  logic [DIGITS-1:0]   new_bit;
  logic                complete;
  logic                handshake;

  // Stability detection on the synced bus and digit decode.
  always_comb begin
    raw     = {seg_n, dig_en};
    same    = (raw == sync_q);
    dig     = sync_q[DIGITS-1:0];
    onehot  = (dig != '0) && ((dig & (dig - 1'b1)) == '0);
    // Fires exactly once, on the edge where the value has been seen STABLE_CYCLES+1 times.
    accept  = same && (cnt_q == CntW'(STABLE_CYCLES - 1)) && onehot;
    dec     = decode_seg(sync_q[SyncW-1:DIGITS]);
    new_bit = accept ? dig : '0;
    bank_bcd_d = bank_bcd_q;
    bank_err_d = bank_err_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (new_bit[i]) begin
        bank_bcd_d[4*i +: 4] = dec[3:0];
        bank_err_d[i]        = dec[4];
      end
    end
    complete = accept && ((seen_q | new_bit) == '1);
  end

  // Frame assembly and output handshake.
  always_comb begin
    state_d   = state_q;
    seen_d    = seen_q | new_bit;
    valid_d   = valid_q;
    bcd_d     = bcd_q;
    err_d     = err_q;
    overrun_d = 1'b0;
    handshake = valid_q && frame_ready;
    case (state_q)
      COLLECT: begin
        if (complete) begin
          bcd_d   = bank_bcd_d;
          err_d   = bank_err_d;
          valid_d = 1'b1;
          seen_d  = '0;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (complete) begin
          seen_d = '0;
          if (handshake) begin
            bcd_d = bank_bcd_d;
            err_d = bank_err_d;
          end else begin
            overrun_d = 1'b1;
          end
        end else if (handshake) begin
          valid_d = 1'b0;
          state_d = COLLECT;
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  // Input sync register and saturating stability counter.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      sync_q <= '0;
      cnt_q  <= '0;
    end else begin
      sync_q <= raw;
      if (!same) begin
        cnt_q <= '0;
      end else if (cnt_q != CntW'(STABLE_CYCLES)) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  // Bank, FSM and output registers.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      bank_bcd_q <= '0;
      bank_err_q <= '0;
      seen_q     <= '0;
      state_q    <= COLLECT;
      valid_q    <= 1'b0;
      bcd_q      <= '0;
      err_q      <= '0;
      overrun_q  <= 1'b0;
    end else begin
      bank_bcd_q <= bank_bcd_d;
      bank_err_q <= bank_err_d;
      seen_q     <= seen_d;
      state_q    <= state_d;
      valid_q    <= valid_d;
      bcd_q      <= bcd_d;
      err_q      <= err_d;
      overrun_q  <= overrun_d;
    end
  end

  assign frame_valid = valid_q;
  assign frame_bcd   = bcd_q;
  assign frame_err   = err_q;
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_seven_seg_frame_reader.sv
// Bench for seven_seg_frame_reader: frames expected by the stimulus are queued
// and compared whenever the DUT completes a valid/ready handshake.
module tb_seven_seg_frame_reader;

  typedef struct packed {
    logic [15:0] bcd;
    logic [3:0]  err;
  } frame_t;

  logic        Clock = 1'b0;
  logic        Resetn = 1'b0;
  logic [6:0]  seg_n = 7'h7F;
  logic [3:0]  dig_en = 4'h0;
  logic        frame_ready = 1'b1;
  logic        frame_valid;
  logic [15:0] frame_bcd;
  logic [3:0]  frame_err;
  logic        overrun;

  int checks = 0;
  int errors = 0;
  int ov_cnt = 0;
  frame_t sb_q[$];

  seven_seg_frame_reader #(
    .DIGITS       (4),
    .STABLE_CYCLES(3)
  ) dut (
    .Clock      (Clock),
    .Resetn     (Resetn),
    .seg_n      (seg_n),
    .dig_en     (dig_en),
    .frame_ready(frame_ready),
    .frame_valid(frame_valid),
    .frame_bcd  (frame_bcd),
    .frame_err  (frame_err),
    .overrun    (overrun)
  );

  always #5 Clock = ~Clock;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [6:0] pat(input logic [3:0] v);
    case (v)
      4'd0: return 7'b0000001;
      4'd1: return 7'b1001111;
      4'd2: return 7'b0010010;
      4'd3: return 7'b0000110;
      4'd4: return 7'b1001100;
      4'd5: return 7'b0100100;
      4'd6: return 7'b0100000;
      4'd7: return 7'b0001111;
      4'd8: return 7'b0000000;
      4'd9: return 7'b0000100;
      default: return 7'b1111111;
    endcase
  endfunction

  task automatic push(input logic [15:0] bcd, input logic [3:0] err);
    frame_t f;
    f.bcd = bcd;
    f.err = err;
    sb_q.push_back(f);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge Clock);
    #1;
  endtask

  task automatic show_digit(input int idx, input logic [6:0] seg, input int cycles);
    seg_n  = seg;
    dig_en = 4'(1 << idx);
    tick(cycles);
  endtask

  // Nibble i of vals is shown on digit i, in index order.
  task automatic scan4(input logic [15:0] vals);
    for (int i = 0; i < 4; i++) show_digit(i, pat(vals[4*i +: 4]), 4);
  endtask

  // Scoreboard consumer: a handshake happens on the next rising edge.
  always @(negedge Clock) begin
    if (overrun) ov_cnt++;
    if (Resetn && frame_valid && frame_ready) begin
      if (sb_q.size() == 0) begin
        check_eq("sb_underflow", {31'd0, frame_valid}, 32'd0);
      end else begin
        frame_t e;
        e = sb_q.pop_front();
        check_eq("frame_bcd", {16'd0, frame_bcd}, {16'd0, e.bcd});
        check_eq("frame_err", {28'd0, frame_err}, {28'd0, e.err});
      end
    end
  end

  initial begin
    // Reset state
    #12;
    check_eq("rst_valid", {31'd0, frame_valid}, 32'd0);
    check_eq("rst_bcd", {16'd0, frame_bcd}, 32'd0);
    check_eq("rst_err", {28'd0, frame_err}, 32'd0);
    check_eq("rst_overrun", {31'd0, overrun}, 32'd0);
    @(posedge Clock);
    #1;
    Resetn = 1'b1;
    tick(2);

    // 1: basic frame plus latency from the final digit
    push(16'h0183, 4'b0000);
    for (int i = 0; i < 3; i++) show_digit(i, pat(4'(16'h0183 >> (4 * i))), 4);
    show_digit(3, pat(4'd0), 3);
    check_eq("lat_before", {31'd0, frame_valid}, 32'd0);
    tick(1);
    check_eq("lat_at", {31'd0, frame_valid}, 32'd1);
    tick(1);
    check_eq("valid_1cyc", {31'd0, frame_valid}, 32'd0);
    tick(2);

    // 2: undecodable pattern on digit 2
    push(16'h7F25, 4'b0100);
    scan4(16'h7F25);
    tick(2);

    // 3: short pulse and multi-hot glitch are ignored
    push(16'h2496, 4'b0000);
    show_digit(0, pat(4'd6), 4);
    show_digit(1, pat(4'd5), 2);
    show_digit(1, pat(4'd9), 4);
    seg_n  = pat(4'd4);
    dig_en = 4'b0011;
    tick(2);
    show_digit(2, pat(4'd4), 4);
    show_digit(3, pat(4'd2), 4);
    tick(2);

    // 4: consumer stalls across two completions
    frame_ready = 1'b0;
    push(16'h4321, 4'b0000);
    scan4(16'h4321);
    scan4(16'h9999);
    tick(2);
    check_eq("ovr_count", ov_cnt, 32'd1);
    check_eq("ovr_valid", {31'd0, frame_valid}, 32'd1);
    check_eq("ovr_bcd", {16'd0, frame_bcd}, 32'h4321);
    frame_ready = 1'b1;
    tick(1);
    check_eq("ovr_drop", {31'd0, frame_valid}, 32'd0);
    tick(2);

    // 5: handshake on the completion edge gives back-to-back frames
    frame_ready = 1'b0;
    push(16'h3210, 4'b0000);
    scan4(16'h3210);
    push(16'h5678, 4'b0000);
    show_digit(0, pat(4'd8), 4);
    show_digit(1, pat(4'd7), 4);
    show_digit(2, pat(4'd6), 4);
    show_digit(3, pat(4'd5), 3);
    frame_ready = 1'b1;
    tick(1);
    check_eq("b2b_valid", {31'd0, frame_valid}, 32'd1);
    check_eq("b2b_bcd", {16'd0, frame_bcd}, 32'h5678);
    tick(2);
    check_eq("b2b_drain", {31'd0, frame_valid}, 32'd0);
    check_eq("ovr_total", ov_cnt, 32'd1);

    // 6: reset with a held frame and a partial frame in progress
    frame_ready = 1'b0;
    scan4(16'h2222);
    show_digit(0, pat(4'd9), 4);
    show_digit(1, pat(4'd9), 4);
    #3;
    Resetn = 1'b0;
    #2;
    check_eq("mid_rst_valid", {31'd0, frame_valid}, 32'd0);
    check_eq("mid_rst_bcd", {16'd0, frame_bcd}, 32'd0);
    check_eq("mid_rst_err", {28'd0, frame_err}, 32'd0);
    check_eq("mid_rst_ovr", {31'd0, overrun}, 32'd0);
    tick(2);
    Resetn = 1'b1;
    frame_ready = 1'b1;
    // Digits 2,3 first: stale seen bits would complete a frame early.
    push(16'h3741, 4'b0000);
    show_digit(2, pat(4'd7), 4);
    show_digit(3, pat(4'd3), 4);
    check_eq("post_rst_partial", {31'd0, frame_valid}, 32'd0);
    show_digit(0, pat(4'd1), 4);
    show_digit(1, pat(4'd4), 4);
    tick(3);
    check_eq("sb_drained", sb_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // The held 16'h2222 frame is discarded by the reset, so drop its entry.
  always @(negedge Resetn) begin
    if (sb_q.size() > 0 && sb_q[0].bcd == 16'h2222) sb_q.delete();
  end

  // The frame for 16'h2222 is queued at the moment it completes.
  initial begin
    wait (checks > 0);
    forever begin
      @(posedge Clock);
      #2;
      if (Resetn && frame_valid && frame_bcd == 16'h2222 && sb_q.size() == 0 && !frame_ready)
        push(16'h2222, 4'b0000);
    end
  end

endmodule
